// File: rtl/fuzzy_aggregator_seq.sv
// Sequential fuzzy-rule aggregator: walks the latched rules one per cycle,
// accumulating clipped weights and floor(w*g/100) terms, then publishes clamped Q1.15 sums.
module fuzzy_aggregator_seq #(
    parameter int unsigned N_RULES = 9,
    parameter int unsigned W_W     = 16,
    parameter int unsigned W_G     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_RULES-1:0]       rule_mask,
    input  logic [N_RULES*W_W-1:0]   w_flat,
    input  logic [N_RULES*W_G-1:0]   g_flat,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              S_w,
    output logic [15:0]              S_wg,
    output logic                     sat_w,
    output logic                     sat_wg
);

    localparam int unsigned IDX_W  = (N_RULES > 1) ? $clog2(N_RULES) : 1;
    localparam int unsigned ACC_W  = W_W + $clog2(N_RULES) + 1;
    localparam int unsigned PROD_W = W_W + W_G;

    localparam logic [W_W-1:0]    W_MAX     = W_W'(16'h7FFF);
    localparam logic [W_G-1:0]    G_MAX     = W_G'(100);
    localparam logic [ACC_W-1:0]  ACC_CLAMP = ACC_W'(16'h7FFF);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_RULES - 1);
    localparam logic [PROD_W-1:0] DIV_100   = PROD_W'(100);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_PUBLISH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [N_RULES-1:0]  r_mask;
    logic [W_W-1:0]      r_w [N_RULES];
    logic [W_G-1:0]      r_g [N_RULES];
    logic [IDX_W-1:0]    r_idx;
    logic [ACC_W-1:0]    r_acc_w;
    logic [ACC_W-1:0]    r_acc_wg;

    logic                r_done;
    logic [15:0]         r_s_w;
    logic [15:0]         r_s_wg;
    logic                r_sat_w;
    logic                r_sat_wg;

    logic                w_accept;
    logic                w_last;
    logic                w_en;
    logic [W_W-1:0]      w_w_sel;
    logic [W_G-1:0]      w_g_sel;
    logic [W_W-1:0]      w_w_clip;
    logic [W_G-1:0]      w_g_clip;
    logic [PROD_W-1:0]   w_prod;
    logic [PROD_W-1:0]   w_term;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_idx == IDX_LAST);

    // Per-rule term for the rule currently addressed by r_idx
    always_comb begin
        w_en     = r_mask[r_idx];
        w_w_sel  = r_w[r_idx];
        w_g_sel  = r_g[r_idx];
        w_w_clip = (w_w_sel > W_MAX) ? W_MAX : w_w_sel;
        w_g_clip = (w_g_sel > G_MAX) ? G_MAX : w_g_sel;
        w_prod   = PROD_W'(w_w_clip) * PROD_W'(w_g_clip);
        w_term   = w_prod / DIV_100;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_ACC;
            ST_ACC:     if (w_last) w_state_nxt = ST_PUBLISH;
            ST_PUBLISH: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand snapshot; only reloaded on an accepted start
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mask <= rule_mask;
            for (int unsigned i = 0; i < N_RULES; i++) begin
                r_w[i] <= w_flat[i*W_W +: W_W];
                r_g[i] <= g_flat[i*W_G +: W_G];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_acc_w  <= '0;
            r_acc_wg <= '0;
            r_done   <= 1'b0;
            r_s_w    <= '0;
            r_s_wg   <= '0;
            r_sat_w  <= 1'b0;
            r_sat_wg <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx    <= '0;
                        r_acc_w  <= '0;
                        r_acc_wg <= '0;
                    end
                end
                ST_ACC: begin
                    if (w_en) begin
                        r_acc_w  <= r_acc_w + ACC_W'(w_w_clip);
                        r_acc_wg <= r_acc_wg + ACC_W'(w_term);
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    r_s_w    <= (r_acc_w > ACC_CLAMP) ? 16'h7FFF : r_acc_w[15:0];
                    r_s_wg   <= (r_acc_wg > ACC_CLAMP) ? 16'h7FFF : r_acc_wg[15:0];
                    r_sat_w  <= (r_acc_w > ACC_CLAMP);
                    r_sat_wg <= (r_acc_wg > ACC_CLAMP);
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign S_w    = r_s_w;
    assign S_wg   = r_s_wg;
    assign sat_w  = r_sat_w;
    assign sat_wg = r_sat_wg;

endmodule

// File: tb/tb_fuzzy_aggregator_seq.sv
// Self-checking bench for fuzzy_aggregator_seq: directed corner runs plus randomized
// runs compared against a plain-arithmetic reference of the aggregation rules.
module tb_fuzzy_aggregator_seq;

    localparam int N = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N-1:0]     rule_mask;
    logic [N*16-1:0]  w_flat;
    logic [N*8-1:0]   g_flat;
    logic             busy;
    logic             done;
    logic [15:0]      S_w;
    logic [15:0]      S_wg;
    logic             sat_w;
    logic             sat_wg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]  tw [N];
    logic [7:0]   tg [N];
    logic [N-1:0] tmask;

    always #5 clk = ~clk;

    fuzzy_aggregator_seq #(
        .N_RULES (N),
        .W_W     (16),
        .W_G     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rule_mask (rule_mask),
        .w_flat    (w_flat),
        .g_flat    (g_flat),
        .busy      (busy),
        .done      (done),
        .S_w       (S_w),
        .S_wg      (S_wg),
        .sat_w     (sat_w),
        .sat_wg    (sat_wg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of clipped weights and per-term floored products, then clamp
    task automatic model(output int e_w, output int e_wg, output bit e_sw, output bit e_swg);
        int sw = 0;
        int swg = 0;
        for (int i = 0; i < N; i++) begin
            if (tmask[i]) begin
                int wc = (int'(tw[i]) > 32767) ? 32767 : int'(tw[i]);
                int gc = (int'(tg[i]) > 100) ? 100 : int'(tg[i]);
                sw  += wc;
                swg += (wc * gc) / 100;
            end
        end
        e_sw  = (sw > 32767);
        e_swg = (swg > 32767);
        e_w   = e_sw ? 32767 : sw;
        e_wg  = e_swg ? 32767 : swg;
    endtask

    task automatic drive_inputs();
        rule_mask = tmask;
        for (int i = 0; i < N; i++) begin
            w_flat[i*16 +: 16] = tw[i];
            g_flat[i*8 +: 8]   = tg[i];
        end
    endtask

    task automatic scramble_inputs();
        rule_mask = N'($urandom);
        for (int i = 0; i < N; i++) begin
            w_flat[i*16 +: 16] = 16'($urandom);
            g_flat[i*8 +: 8]   = 8'($urandom);
        end
    endtask

    task automatic fill(input logic [N-1:0] m, input logic [15:0] w, input logic [7:0] g);
        tmask = m;
        for (int i = 0; i < N; i++) begin
            tw[i] = w;
            tg[i] = g;
        end
    endtask

    // Called away from the clock edge; start is taken on the next rising edge
    task automatic run_check(input string tag, input bit gap);
        int e_w, e_wg, cnt;
        bit e_sw, e_swg, got;
        model(e_w, e_wg, e_sw, e_swg);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        check({tag, ":busy_after_accept"}, 32'(busy), 32'd1);
        cnt = 0;
        got = 0;
        while (cnt < 40 && !got) begin
            @(posedge clk); #1;
            cnt++;
            start = 1'b0;
            if (done) got = 1;
            else start = (cnt == 2 || cnt == 5);
        end
        start = 1'b0;
        check({tag, ":latency"}, 32'(cnt), 32'(N + 1));
        check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ":S_w"}, 32'(S_w), 32'(e_w));
        check({tag, ":S_wg"}, 32'(S_wg), 32'(e_wg));
        check({tag, ":sat_w"}, 32'(sat_w), 32'(e_sw));
        check({tag, ":sat_wg"}, 32'(sat_wg), 32'(e_swg));
        if (gap) begin
            @(posedge clk); #1;
            check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
            check({tag, ":S_w_hold"}, 32'(S_w), 32'(e_w));
            check({tag, ":S_wg_hold"}, 32'(S_wg), 32'(e_wg));
        end
    endtask

    initial begin
        bit seen_done;
        rst   = 1'b1;
        start = 1'b0;
        fill('1, 16'h0800, 8'd50);
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:S_w", 32'(S_w), 32'd0);
        check("reset:S_wg", 32'(S_wg), 32'd0);
        check("reset:sat_w", 32'(sat_w), 32'd0);
        check("reset:sat_wg", 32'(sat_wg), 32'd0);
        // start asserted together with reset must not launch a run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("reset_over_start:busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill(9'h1FF, 16'h0800, 8'd50);
        check("ref036:S_w", 32'(0), 32'(0)); n_tests--;
        run_check("r036", 1'b0);
        // launched in the done cycle of the previous run
        fill(9'h0BA, 16'h1000, 8'd100);
        run_check("r037", 1'b1);
        for (int i = 0; i < N; i++) begin
            if (!tmask[i]) begin
                tw[i] = 16'hFFFF;
                tg[i] = 8'd255;
            end
        end
        run_check("r037_junk_off", 1'b1);
        fill(9'h1FF, 16'h7FFF, 8'd100);
        run_check("r038_sat", 1'b0);
        fill('0, 16'h7FFF, 8'd100);
        run_check("r038_mask0", 1'b1);
        fill(9'h001, 16'h1234, 8'd77);
        tw[0] = 16'h9000;
        tg[0] = 8'd200;
        run_check("r039", 1'b1);
        fill(9'h1FF, 16'h0003, 8'd33);
        run_check("r040", 1'b1);

        // abort a run in its 4th ACC cycle
        fill(9'h1FF, 16'h0800, 8'd50);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:done", 32'(done), 32'd0);
        check("abort:S_w", 32'(S_w), 32'd0);
        check("abort:S_wg", 32'(S_wg), 32'd0);
        check("abort:sat_w", 32'(sat_w), 32'd0);
        seen_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("abort:no_done", 32'(seen_done), 32'd0);
        fill(9'h1FF, 16'h0800, 8'd50);
        run_check("after_abort", 1'b1);

        for (int r = 0; r < 25; r++) begin
            tmask = N'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       tw[i] = 16'($urandom_range(32768, 65535));
                    1:       tw[i] = 16'($urandom_range(0, 64));
                    default: tw[i] = 16'($urandom_range(0, 32767));
                endcase
                tg[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(101, 255))
                                                    : 8'($urandom_range(0, 100));
            end
            run_check($sformatf("rand%0d", r), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
